// File: rtl/alu_pkg.sv
// Shared definitions for the ALU flag stage: default datapath width,
// flag bit positions inside the 4-bit {N,Z,C,V} vector, and the layout
// of one result FIFO entry.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int FLAG_W    = 4;

  // Bit positions inside out_flags = {N,Z,C,V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // One queued result at the default width. The stage packs entries as
  // {sum, flags} so that any width follows this same layout.
  typedef struct packed {
    logic [ALU_WIDTH-1:0] sum;
    logic [FLAG_W-1:0]    flags;
  } alu_entry_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Synchronous result FIFO for the ALU flag stage. DEPTH entries of DW
// bits, in-order, with an occupancy count. A simultaneous push and pop
// leaves the count unchanged, including when full: the write lands in
// the slot that is being read out on that same edge. The caller never
// pushes into a full FIFO without a pop and never pops when empty.
module alu_result_fifo #(
  parameter int DW    = 36,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          valid,
  output logic [AW:0]   count
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  // Next-state: pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // State registers; reset empties the FIFO and clears storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign valid    = (count_q != '0);
  assign count    = count_q;

endmodule

// File: rtl/alu_flag_stage.sv
// ALU flag stage: tracks issues into an external LATENCY-deep pipelined
// adder, captures the adder sum/carry when each issue emerges, derives
// {N,Z,C,V} and queues {sum, flags} in a result FIFO.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where
// valid && ready are both high. in_valid without in_ready is ignored and
// the matching adder result is dropped. out_sum/out_flags are held
// stable while out_valid && !out_ready.
//
// Credit: in_ready is high while (issues in flight + queued results) is
// below DEPTH, computed from registered state only, so every issue has a
// guaranteed FIFO slot and a pop only frees credit on the following cycle.
//
// Optional feature macro ALU_FLAG_STICKY_OVF_EN: adds clr_ovf/sticky_ovf,
// a sticky record of any queued result with V = 1.
module alu_flag_stage
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic [WIDTH-1:0] s,
  input  logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [3:0]       out_flags
`ifdef ALU_FLAG_STICKY_OVF_EN
  ,
  input  logic             clr_ovf,
  output logic             sticky_ovf
`endif
);

  localparam int EW  = WIDTH + FLAG_W;
  localparam int FCW = $clog2(DEPTH) + 1;
  localparam int CW  = $clog2(LATENCY + DEPTH + 1);

  logic [LATENCY-1:0] tok_q,  tok_d;
  logic [LATENCY-1:0] amsb_q, amsb_d;
  logic [LATENCY-1:0] bmsb_q, bmsb_d;

  logic           issue;
  logic           push;
  logic           pop;
  logic [3:0]     new_flags;
  logic [EW-1:0]  fifo_wdata;
  logic [EW-1:0]  fifo_rdata;
  logic           fifo_valid;
  logic [FCW-1:0] fifo_count;
  logic [CW-1:0]  occ;
  logic           last_a;
  logic           last_b;

  assign issue  = in_valid && in_ready;
  assign push   = tok_q[LATENCY-1];
  assign last_a = amsb_q[LATENCY-1];
  assign last_b = bmsb_q[LATENCY-1];

  // Token shift register mirrors the adder pipeline; operand sign bits
  // travel alongside so overflow can be judged when the sum arrives.
  always_comb begin
    tok_d     = '0;
    amsb_d    = '0;
    bmsb_d    = '0;
    tok_d[0]  = issue;
    amsb_d[0] = a_msb;
    bmsb_d[0] = b_msb;
    for (int i = 1; i < LATENCY; i++) begin
      tok_d[i]  = tok_q[i-1];
      amsb_d[i] = amsb_q[i-1];
      bmsb_d[i] = bmsb_q[i-1];
    end
  end

  // Pipeline tracking registers; reset discards every in-flight token.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tok_q  <= '0;
      amsb_q <= '0;
      bmsb_q <= '0;
    end else begin
      tok_q  <= tok_d;
      amsb_q <= amsb_d;
      bmsb_q <= bmsb_d;
    end
  end

  // Flags for the sum currently leaving the adder.
  always_comb begin
    new_flags         = '0;
    new_flags[FLAG_N] = s[WIDTH-1];
    new_flags[FLAG_Z] = (s == '0);
    new_flags[FLAG_C] = cout;
    new_flags[FLAG_V] = (last_a == last_b) && (s[WIDTH-1] != last_a);
  end

  assign fifo_wdata = {s, new_flags};

  alu_result_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (fifo_wdata),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign pop       = fifo_valid && out_ready;
  assign out_valid = fifo_valid;
  assign out_sum   = fifo_valid ? fifo_rdata[EW-1:FLAG_W] : '0;
  assign out_flags = fifo_valid ? fifo_rdata[FLAG_W-1:0]  : '0;

  // Credit check: queued results plus tokens still in the adder; held low
  // while reset is asserted.
  always_comb begin
    occ = CW'(fifo_count);
    for (int i = 0; i < LATENCY; i++) begin
      occ = occ + CW'(tok_q[i]);
    end
    in_ready = reset && (occ < CW'(DEPTH));
  end

`ifdef ALU_FLAG_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // Sticky overflow: a queued V = 1 result sets it and wins over clear.
  always_comb begin
    sticky_d = sticky_q;
    if (push && new_flags[FLAG_V]) begin
      sticky_d = 1'b1;
    end else if (clr_ovf) begin
      sticky_d = 1'b0;
    end
  end

  // Sticky overflow register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_ovf = sticky_q;
`endif

endmodule

// File: tb/tb_alu_flag_stage.sv
// Directed bench for alu_flag_stage (WIDTH=32, LATENCY=4, DEPTH=4).
// A free-running pipelined adder model feeds s/cout; every issued
// vector carries a hand-computed {sum, flags} into the scoreboard.
module tb_alu_flag_stage;

  localparam int W   = 32;
  localparam int LAT = 4;
  localparam int DEP = 4;
  localparam int EW  = W + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in, b_in;
  logic         c_in;
  logic         a_msb, b_msb;
  logic [W-1:0] s;
  logic         cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic [3:0]   out_flags;
`ifdef ALU_FLAG_STICKY_OVF_EN
  logic         clr_ovf;
  logic         sticky_ovf;
`endif

  assign a_msb = a_in[W-1];
  assign b_msb = b_in[W-1];

  alu_flag_stage #(
    .WIDTH   (W),
    .LATENCY (LAT),
    .DEPTH   (DEP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_msb      (a_msb),
    .b_msb      (b_msb),
    .s          (s),
    .cout       (cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_flags  (out_flags)
`ifdef ALU_FLAG_STICKY_OVF_EN
    ,
    .clr_ovf    (clr_ovf),
    .sticky_ovf (sticky_ovf)
`endif
  );

  // ---------------- upstream adder model ----------------
  logic [W-1:0] pa [LAT];
  logic [W-1:0] pb [LAT];
  logic         pc [LAT];
  logic [W:0]   sum_w;

  always @(posedge clk) begin
    pa[0] <= a_in;
    pb[0] <= b_in;
    pc[0] <= c_in;
    for (int i = 1; i < LAT; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
      pc[i] <= pc[i-1];
    end
  end

  assign sum_w = {1'b0, pa[LAT-1]} + {1'b0, pb[LAT-1]} + {{W{1'b0}}, pc[LAT-1]};
  assign s     = sum_w[W-1:0];
  assign cout  = sum_w[W];

  // ---------------- scoreboard ----------------
  int            tests_run    = 0;
  int            tests_failed = 0;
  logic [EW-1:0] exp_q[$];
  logic          popped;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: drive at the falling edge, sample 1 ns later.
  task automatic cycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic [W-1:0] es, input logic [3:0] ef,
                       input logic ordy);
    logic [EW-1:0] e;
    @(negedge clk);
    in_valid  = iv;
    a_in      = a;
    b_in      = b;
    c_in      = c;
    out_ready = ordy;
    #1;
    popped = 1'b0;
    if (iv && in_ready) exp_q.push_back({es, ef});
    if (out_valid && out_ready) begin
      popped = 1'b1;
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_sum", 64'(out_sum), 64'(e[EW-1:4]));
        check("out_flags", 64'(out_flags), 64'(e[3:0]));
      end
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, '0, 1'b0, '0, 4'b0000, ordy);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) idle(1'b1);
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int   accepted;
  logic got_first;

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    c_in      = 1'b0;
    out_ready = 1'b0;
    popped    = 1'b0;
`ifdef ALU_FLAG_STICKY_OVF_EN
    clr_ovf   = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum",   64'(out_sum),   64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
`ifdef ALU_FLAG_STICKY_OVF_EN
    check("rst_sticky", 64'(sticky_ovf), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ready_after_release", 64'(in_ready), 64'd1);

    // Basic add with carry-in and latency: valid only after LATENCY+1 edges
    cycle(1'b1, 32'h1111_1111, 32'h3333_3333, 1'b1, 32'h4444_4445, 4'b0000, 1'b0);
    repeat (4) idle(1'b0);
    check("lat_not_early", 64'(out_valid), 64'd0);
    idle(1'b0);
    check("lat_valid", 64'(out_valid), 64'd1);
    drain(5);

    // Signed overflow, zero with carry, overflow with carry and zero
    cycle(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1001, 1'b1);
    cycle(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0110, 1'b1);
    cycle(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 4'b0111, 1'b1);
    drain(20);
`ifdef ALU_FLAG_STICKY_OVF_EN
    check("sticky_set", 64'(sticky_ovf), 64'd1);
    clr_ovf = 1'b1;
    idle(1'b1);
    clr_ovf = 1'b0;
    check("sticky_clr", 64'(sticky_ovf), 64'd0);
`endif

    // Back-to-back results pop on consecutive cycles
    cycle(1'b1, 32'h4444_4444, 32'h3333_3333, 1'b0, 32'h7777_7777, 4'b0000, 1'b1);
    cycle(1'b1, 32'h1111_1111, 32'h3333_3333, 1'b1, 32'h4444_4445, 4'b0000, 1'b1);
    for (int i = 0; i < 20 && !popped; i++) idle(1'b1);
    got_first = popped;
    check("b2b_first_seen", 64'(got_first), 64'd1);
    idle(1'b1);
    check("b2b_consecutive", 64'(popped), 64'd1);
    check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

    // Fill with out_ready low: exactly DEPTH accepted, then in_ready low
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, W'(i), 32'h0000_0100, 1'b0, 32'h0000_0100 + W'(i), 4'b0000, 1'b0);
      if (in_ready) accepted++;
    end
    check("fill_accepted", 64'(accepted), 64'(DEP));
    idle(1'b0);
    check("fill_ready_low", 64'(in_ready),  64'd0);
    check("fill_valid",     64'(out_valid), 64'd1);
    check("hold_sum_a",     64'(out_sum),   64'h100);
    idle(1'b0);
    check("hold_sum_b",     64'(out_sum),   64'h100);
    check("hold_flags",     64'(out_flags), 64'd0);
    idle(1'b1);
    check("ready_no_comb",  64'(in_ready),  64'd0);
    drain(20);
    check("ready_returns",  64'(in_ready),  64'd1);

    // Reset with one queued result and two in flight
    cycle(1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 4'b0000, 1'b0);
    repeat (5) idle(1'b0);
    check("mid_queued", 64'(out_valid), 64'd1);
    cycle(1'b1, 32'h0000_0005, 32'h0000_0006, 1'b0, 32'h0000_000B, 4'b0000, 1'b0);
    cycle(1'b1, 32'h0000_0007, 32'h0000_0008, 1'b0, 32'h0000_000F, 4'b0000, 1'b0);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sum",   64'(out_sum),   64'd0);
    check("mid_rst_ready", 64'(in_ready),  64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_release_ready", 64'(in_ready), 64'd1);
    repeat (12) idle(1'b1);
    check("no_stale_valid", 64'(out_valid), 64'd0);

    // Operation resumes after reset
    cycle(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 4'b1001, 1'b1);
    drain(20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_flag_stage.md
ALU_FLAG_STAGE -- requirements
Module: alu_flag_stage

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of the upstream pipelined prefix adder.
REQ-002 Parameter LATENCY, default 4, adder pipeline depth in clock edges (range 1..8).
REQ-003 Parameter DEPTH, default 4, result FIFO entries (power of two, >= 2).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operands a, b, c presented to the adder this cycle.
REQ-007 in_ready  output  1  block can accept a new adder issue.
REQ-008 a_msb  input  1  bit WIDTH-1 of operand a, coincident with in_valid.
REQ-009 b_msb  input  1  bit WIDTH-1 of operand b as fed to adder, coincident with in_valid.
REQ-010 s  input  WIDTH  adder sum output.
REQ-011 cout  input  1  adder carry-out.
REQ-012 out_valid  output  1  out_sum/out_flags hold a result.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_sum  output  WIDTH  registered sum.
REQ-015 out_flags  output  4  {N,Z,C,V}.

Function
REQ-016 Issue accepted at edge k when in_valid && in_ready; a_msb, b_msb and a valid token enter a LATENCY-deep shift register.
REQ-017 Token reaching the last stage samples s/cout at edge k+LATENCY and pushes {s, flags} into the FIFO; out_valid rises after that edge if FIFO was empty (no combinational bypass).
REQ-018 Flags: N = s[WIDTH-1]; Z = (s == 0); C = cout; V = (a_msb == b_msb) && (s[WIDTH-1] != a_msb).
REQ-019 Pop at edge where out_valid && out_ready; FIFO is in order, no reordering or drops.
REQ-020 in_ready = (tokens in flight + FIFO count) < DEPTH, derived from registered state only; pops in the current cycle do not raise it until the next cycle.
REQ-021 Credit rule guarantees no FIFO overflow; push and pop in same edge leave count unchanged, including when full.
REQ-022 in_valid while in_ready low is ignored: no token, result silently dropped.
REQ-023 out_sum/out_flags hold stable while out_valid && !out_ready.
REQ-024 Throughput: one result per cycle sustained when out_ready held high.

Reset
REQ-025 reset low: shift register cleared, FIFO emptied, out_valid = 0, out_sum = 0, out_flags = 0, in_ready = 0.
REQ-026 Reset mid-operation discards all in-flight tokens and queued results; in_ready = 1 in the first cycle after reset release.

Configuration
REQ-027 Macro ALU_FLAG_STICKY_OVF_EN defined: adds input clr_ovf (1) and output sticky_ovf (1); sticky_ovf sets on any push with V = 1, clears on clr_ovf, set wins when both are active in the same cycle, resets to 0.
REQ-028 Macro undefined: ports clr_ovf and sticky_ovf absent; no related logic.

Structure
REQ-029 Shared package alu_pkg holds WIDTH default, flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0, and a typedef for the {sum, flags} FIFO entry.
REQ-030 Sub-module alu_result_fifo (DEPTH x entry, synchronous, count output) is instantiated once; token shift register and flag logic stay in alu_flag_stage.

Verification
REQ-031 a=0x11111111, b=0x33333333, c=1 -> after LATENCY+1 edges out_sum=0x44444445, flags N0 Z0 C0 V0.
REQ-032 a=0x7FFFFFFF, b=0x00000001, c=0 -> out_sum=0x80000000, flags N1 Z0 C0 V1; sticky_ovf=1 when macro defined.
REQ-033 a=0xFFFFFFFF, b=0x00000001, c=0 -> out_sum=0x00000000, flags N0 Z1 C1 V0.
REQ-034 out_ready=0, issue on every cycle -> exactly DEPTH accepted, in_ready low afterwards; release out_ready -> DEPTH results in issue order, in_ready returns.
REQ-035 Back-to-back 0x44444444+0x33333333 (c=0) then 0x11111111+0x33333333 (c=1), out_ready=1 -> 0x77777777 then 0x44444445 on consecutive cycles.
REQ-036 Assert reset with 2 tokens in flight and 1 queued -> out_valid=0 immediately; no stale result appears after release.
